// File: rtl/l2_i_responder_if.sv
//==============================================================================
// Module      : l2_i_responder_if
// Description : L1-facing read port and memory-facing read port of the L2
//               instruction responder.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface l2_i_responder_if;
    logic [63:0]  S_R_ADDR;
    logic         S_R_ADDR_VALID;
    logic [511:0] S_R_DATA;
    logic         S_R_DATA_VALID;
    logic [63:0]  M_R_ADDR;
    logic         M_R_ADDR_VALID;
    logic [63:0]  M_R_DATA;
    logic         M_R_DATA_VALID;

    // Responder side: serves L1 requests, issues memory line reads
    modport slave (
        input  S_R_ADDR,
        input  S_R_ADDR_VALID,
        output S_R_DATA,
        output S_R_DATA_VALID,
        output M_R_ADDR,
        output M_R_ADDR_VALID,
        input  M_R_DATA,
        input  M_R_DATA_VALID
    );

    // Environment side: L1 requester plus memory
    modport master (
        output S_R_ADDR,
        output S_R_ADDR_VALID,
        input  S_R_DATA,
        input  S_R_DATA_VALID,
        input  M_R_ADDR,
        input  M_R_ADDR_VALID,
        output M_R_DATA,
        output M_R_DATA_VALID
    );
endinterface

`default_nettype wire

// File: rtl/l2_i_responder.sv
//==============================================================================
// Module      : l2_i_responder
// Description : Direct-mapped, read-only L2 instruction cache. Serves one L1
//               line request at a time, refilling 512-bit lines from memory
//               in eight 64-bit beats on a miss.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module l2_i_responder #(
    parameter int LINE_COUNT     = 256,
    parameter int BYTES_PER_LINE = 64
) (
    input  wire logic        clk,
    input  wire logic        reset,
    l2_i_responder_if.slave  bus
);

    localparam int c_off_w  = $clog2(BYTES_PER_LINE);
    localparam int c_idx_w  = $clog2(LINE_COUNT);
    localparam int c_tag_w  = 64 - c_off_w - c_idx_w;
    localparam int c_line_w = BYTES_PER_LINE * 8;
    localparam int c_beat_w = 64;
    localparam int c_fill_w = c_line_w - c_beat_w;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOOKUP   = 3'd1,
        S_MEM_REQ  = 3'd2,
        S_MEM_FILL = 3'd3,
        S_RESPOND  = 3'd4
    } state_t;

    state_t                 r_state;
    logic [63-c_off_w:0]    r_line_addr;
    logic [2:0]             r_beat;
    logic [c_fill_w-1:0]    r_fill;
    logic [LINE_COUNT-1:0]  r_line_valid;
    logic [c_tag_w-1:0]     r_tag_mem  [LINE_COUNT];
    logic [c_line_w-1:0]    r_data_mem [LINE_COUNT];

    logic [c_idx_w-1:0]     w_index;
    logic [c_tag_w-1:0]     w_tag;
    logic                   w_hit;
    logic                   w_fill_done;
    logic [c_line_w-1:0]    w_fill_line;
    logic                   w_unused_offset;

    assign w_index         = r_line_addr[c_idx_w-1:0];
    assign w_tag           = r_line_addr[63-c_off_w:c_idx_w];
    assign w_hit           = r_line_valid[w_index] && (r_tag_mem[w_index] == w_tag);
    assign w_fill_done     = (r_state == S_MEM_FILL) && bus.M_R_DATA_VALID && (r_beat == 3'd7);
    // The final beat is stored straight from the bus, completing the line in one write
    assign w_fill_line     = {bus.M_R_DATA, r_fill};
    assign w_unused_offset = ^bus.S_R_ADDR[c_off_w-1:0];

    always_ff @(posedge clk) begin
        if (w_fill_done) begin
            r_tag_mem[w_index]  <= w_tag;
            r_data_mem[w_index] <= w_fill_line;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state            <= S_IDLE;
            r_line_addr        <= '0;
            r_beat             <= '0;
            r_fill             <= '0;
            r_line_valid       <= '0;
            bus.S_R_DATA       <= '0;
            bus.S_R_DATA_VALID <= 1'b0;
            bus.M_R_ADDR       <= '0;
            bus.M_R_ADDR_VALID <= 1'b0;
        end else begin
            bus.S_R_DATA_VALID <= 1'b0;
            bus.M_R_ADDR_VALID <= 1'b0;
            bus.M_R_ADDR       <= '0;

            case (r_state)
                S_IDLE: begin
                    if (bus.S_R_ADDR_VALID) begin
                        r_line_addr <= bus.S_R_ADDR[63:c_off_w];
                        r_state     <= S_LOOKUP;
                    end
                end

                S_LOOKUP: begin
                    r_state <= w_hit ? S_RESPOND : S_MEM_REQ;
                end

                S_MEM_REQ: begin
                    bus.M_R_ADDR          <= {r_line_addr, {c_off_w{1'b0}}};
                    bus.M_R_ADDR_VALID    <= 1'b1;
                    r_line_valid[w_index] <= 1'b0;
                    r_beat                <= 3'd0;
                    r_state               <= S_MEM_FILL;
                end

                S_MEM_FILL: begin
                    if (bus.M_R_DATA_VALID) begin
                        for (int k = 0; k < 7; k++) begin
                            if (r_beat == 3'(k)) begin
                                r_fill[k*c_beat_w +: c_beat_w] <= bus.M_R_DATA;
                            end
                        end
                        r_beat <= r_beat + 3'd1;
                        if (r_beat == 3'd7) begin
                            r_line_valid[w_index] <= 1'b1;
                            r_state               <= S_RESPOND;
                        end
                    end
                end

                S_RESPOND: begin
                    bus.S_R_DATA       <= r_data_mem[w_index];
                    bus.S_R_DATA_VALID <= 1'b1;
                    r_state            <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_l2_i_responder.sv
//==============================================================================
// Module      : tb_l2_i_responder
// Description : Self-checking bench for l2_i_responder against a line-level
//               cache model with randomized traffic and memory beat gaps.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_l2_i_responder;

    localparam int LC = 256;
    localparam int IW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    l2_i_responder_if bus();

    l2_i_responder #(
        .LINE_COUNT     (LC),
        .BYTES_PER_LINE (64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int m_pulses = 0;
    bit chk_en   = 1'b0;

    logic         exp_s_valid = 1'b0;
    logic [511:0] exp_s_data  = '0;
    logic         exp_m_valid = 1'b0;
    logic [63:0]  exp_m_addr  = '0;

    // Model: a present key means the line is valid
    logic [63:0]  mt [int];
    logic [511:0] md [int];

    logic [511:0] cap_resp;
    logic [63:0]  cap_maddr;
    logic         cap_s_valid_at2;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (bus.M_R_ADDR_VALID === 1'b1) m_pulses++;
            chk("s_data_valid", 512'(bus.S_R_DATA_VALID), 512'(exp_s_valid));
            chk("s_data",       bus.S_R_DATA,             exp_s_data);
            chk("m_addr_valid", 512'(bus.M_R_ADDR_VALID), 512'(exp_m_valid));
            chk("m_addr",       512'(bus.M_R_ADDR),       512'(exp_m_addr));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        exp_s_valid = 1'b0;
        exp_m_valid = 1'b0;
        exp_m_addr  = '0;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic stray();
        bus.M_R_DATA       = rnd64();
        bus.M_R_DATA_VALID = ($urandom_range(0, 1) == 1);
    endtask

    // One full L1 transaction; abort_at>0 resets the DUT after that many beats
    task automatic run_req(input logic [63:0] addr, input bit counting, input int abort_at);
        logic [63:0]  la;
        logic [63:0]  tg;
        logic [63:0]  beat;
        logic [511:0] line;
        int           idx;
        bit           hit;
        bit           aborted;
        la      = {addr[63:6], 6'd0};
        idx     = int'((addr >> 6) % LC);
        tg      = addr >> (6 + IW);
        hit     = md.exists(idx) && (mt[idx] == tg);
        line    = '0;
        aborted = 1'b0;

        bus.S_R_ADDR       = addr;
        bus.S_R_ADDR_VALID = 1'b1;
        bus.M_R_DATA_VALID = 1'b0;
        step();
        bus.S_R_ADDR = rnd64();
        stray();
        step();
        stray();
        step();
        cap_s_valid_at2 = bus.S_R_DATA_VALID;
        if (hit) begin
            exp_s_valid = 1'b1;
            exp_s_data  = md[idx];
            cap_resp    = bus.S_R_DATA;
            bus.S_R_ADDR_VALID = 1'b0;
        end else begin
            exp_m_valid = 1'b1;
            exp_m_addr  = la;
            cap_maddr   = bus.M_R_ADDR;
            md.delete(idx);
            mt.delete(idx);
            bus.M_R_DATA_VALID = 1'b0;
            for (int k = 0; k < 8; k++) begin
                repeat ($urandom_range(0, 3)) begin
                    bus.M_R_DATA       = rnd64();
                    bus.M_R_DATA_VALID = 1'b0;
                    step();
                end
                beat = counting ? 64'(k) : rnd64();
                line[k*64 +: 64]   = beat;
                bus.M_R_DATA       = beat;
                bus.M_R_DATA_VALID = 1'b1;
                step();
                if (abort_at != 0 && k + 1 == abort_at) begin
                    aborted = 1'b1;
                    break;
                end
            end
            if (aborted) begin
                #2;
                reset              = 1'b0;
                bus.S_R_ADDR_VALID = 1'b0;
                exp_s_data         = '0;
                md.delete();
                mt.delete();
                #1;
                chk("abort_s_data",       bus.S_R_DATA,             512'd0);
                chk("abort_s_data_valid", 512'(bus.S_R_DATA_VALID), 512'd0);
                chk("abort_m_addr",       512'(bus.M_R_ADDR),       512'd0);
                chk("abort_m_addr_valid", 512'(bus.M_R_ADDR_VALID), 512'd0);
                for (int k = abort_at; k < 8; k++) begin
                    bus.M_R_DATA       = rnd64();
                    bus.M_R_DATA_VALID = 1'b1;
                    step();
                    if (k == abort_at + 1) reset = 1'b1;
                end
                reset = 1'b1;
            end else begin
                bus.M_R_DATA_VALID = 1'b0;
                step();
                md[idx]     = line;
                mt[idx]     = tg;
                exp_s_valid = 1'b1;
                exp_s_data  = line;
                cap_resp    = bus.S_R_DATA;
                bus.S_R_ADDR_VALID = 1'b0;
            end
        end
        bus.S_R_ADDR_VALID = 1'b0;
        step();
        bus.M_R_DATA_VALID = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t actual=timeout required=finish", $time);
        $fatal(1);
    end

    initial begin
        logic [511:0] lit;
        logic [63:0]  addr;
        logic [63:0]  tag;
        logic [63:0]  tag_pool [3];
        int           idx_pool [4];
        int           p;

        for (int k = 0; k < 8; k++) lit[k*64 +: 64] = 64'(k);
        tag_pool[0] = 64'd0;
        tag_pool[1] = 64'd1;
        tag_pool[2] = 64'h0003_FFFF_FFFF_FFFF;
        idx_pool[0] = 1; idx_pool[1] = 2; idx_pool[2] = 3; idx_pool[3] = 5;

        reset              = 1'b1;
        bus.S_R_ADDR       = '0;
        bus.S_R_ADDR_VALID = 1'b0;
        bus.M_R_DATA       = '0;
        bus.M_R_DATA_VALID = 1'b0;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("reset_s_data",       bus.S_R_DATA,             512'd0);
        chk("reset_s_data_valid", 512'(bus.S_R_DATA_VALID), 512'd0);
        chk("reset_m_addr",       512'(bus.M_R_ADDR),       512'd0);
        chk("reset_m_addr_valid", 512'(bus.M_R_ADDR_VALID), 512'd0);
        step();
        reset = 1'b1;
        step();
        step();

        // Cold miss with counting beats
        run_req(64'h1040, 1'b1, 0);
        chk("cold_m_addr", 512'(cap_maddr), 512'h1040);
        chk("cold_lo",     512'(cap_resp[63:0]),    512'd0);
        chk("cold_hi",     512'(cap_resp[511:448]), 512'd7);
        chk("cold_pulses", 512'(m_pulses), 512'd1);

        repeat (5) begin
            stray();
            step();
        end
        bus.M_R_DATA_VALID = 1'b0;

        run_req(64'h1047, 1'b0, 0);
        chk("hit_pulses",  512'(m_pulses), 512'd1);
        chk("hit_latency", 512'(cap_s_valid_at2), 512'd1);
        chk("hit_data",    cap_resp, lit);

        run_req(64'h1040 + 64'(LC * 64), 1'b0, 0);
        chk("conflict_m_addr", 512'(cap_maddr), 512'h5040);
        chk("conflict_pulses", 512'(m_pulses), 512'd2);
        run_req(64'h1040, 1'b1, 0);
        chk("evicted_pulses", 512'(m_pulses), 512'd3);
        chk("refill_data",    cap_resp, lit);

        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 2)) begin
                stray();
                step();
            end
            bus.M_R_DATA_VALID = 1'b0;
            tag  = tag_pool[$urandom_range(0, 2)];
            addr = (tag << (6 + IW)) | (64'(idx_pool[$urandom_range(0, 3)]) << 6)
                 | 64'($urandom_range(0, 63));
            run_req(addr, 1'b0, 0);
        end

        // Reset after the fourth beat of a fill, then re-request the same line
        run_req(64'h0000_7000_0000_2080, 1'b0, 4);
        step();
        p = m_pulses;
        run_req(64'h0000_7000_0000_2080, 1'b0, 0);
        chk("rerequest_miss", 512'(m_pulses), 512'(p + 1));
        p = m_pulses;
        run_req(64'h1047, 1'b0, 0);
        chk("post_reset_miss", 512'(m_pulses), 512'(p + 1));

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/l2_i_responder.md
L2_I_RESPONDER -- requirements
Module: l2_i_responder

Interface
REQ-001 SHALL have parameter LINE_COUNT, default 256, number of direct-mapped lines (power of two).
REQ-002 SHALL have parameter BYTES_PER_LINE, default 64, line size; fixed at 64 (512-bit line, 8 memory beats).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port S_R_ADDR  input  64  requested byte address from L1.
REQ-006 SHALL have port S_R_ADDR_VALID  input  1  request valid, held by L1 until the response.
REQ-007 SHALL have port S_R_DATA  output  512  returned line, registered.
REQ-008 SHALL have port S_R_DATA_VALID  output  1  one-cycle response pulse, registered.
REQ-009 SHALL have port M_R_ADDR  output  64  line-aligned memory read address, registered.
REQ-010 SHALL have port M_R_ADDR_VALID  output  1  one-cycle memory request pulse, registered.
REQ-011 SHALL have port M_R_DATA  input  64  memory read beat.
REQ-012 SHALL have port M_R_DATA_VALID  input  1  beat valid; exactly 8 beats per request, any gaps.

Function
REQ-013 SHALL split the address as offset [5:0], index [6+log2(LINE_COUNT)-1:6], tag = remaining upper bits; each line stores data, valid, tag.
REQ-014 SHALL implement states IDLE, LOOKUP, MEM_REQ, MEM_FILL, RESPOND.
REQ-015 IDLE: when S_R_ADDR_VALID=1, SHALL latch S_R_ADDR with offset zeroed and go to LOOKUP; otherwise stay.
REQ-016 LOOKUP: SHALL compare the latched tag with the indexed line; on valid and tag match go to RESPOND, else go to MEM_REQ.
REQ-017 MEM_REQ: SHALL drive M_R_ADDR = latched aligned address and M_R_ADDR_VALID=1 for exactly one cycle, clear the indexed line's valid bit, clear the beat counter, go to MEM_FILL.
REQ-018 MEM_FILL: SHALL write each M_R_DATA with M_R_DATA_VALID=1 into fill-buffer bits [64k+63:64k], k = 3-bit beat counter, then increment k.
REQ-019 On the beat with k=7, SHALL write the fill buffer (including that beat) to the indexed line with valid=1 and the latched tag, wrap k to 0, go to RESPOND.
REQ-020 RESPOND: SHALL drive S_R_DATA with the indexed line (or the just-completed fill) and S_R_DATA_VALID=1 for exactly one cycle, then return to IDLE.
REQ-021 Hit latency SHALL be 2 cycles from the IDLE accept edge to S_R_DATA_VALID; miss latency = 3 cycles + memory beat time.
REQ-022 S_R_DATA SHALL hold its last value when S_R_DATA_VALID=0; M_R_ADDR SHALL return to 0 after the request pulse.
REQ-023 SHALL ignore M_R_DATA_VALID outside MEM_FILL (stray beats discarded, no state change).
REQ-024 SHALL ignore S_R_ADDR and S_R_ADDR_VALID changes outside IDLE; the latched address governs the transaction.
REQ-025 The requester SHALL drop S_R_ADDR_VALID in the cycle after the pulse; if still high in IDLE it is treated as a new request.
REQ-026 Two requests to the same index with different tags SHALL evict the older line (direct-mapped replacement, no writeback).

Reset
REQ-027 While reset=0, SHALL asynchronously force state=IDLE, all line valid bits=0, beat counter=0, S_R_DATA=0, S_R_DATA_VALID=0, M_R_ADDR=0, M_R_ADDR_VALID=0.
REQ-028 Reset mid-fill SHALL abort the transaction; the target line stays invalid and later beats of the aborted fill are ignored per REQ-023.
REQ-029 After reset release, the first request to any address SHALL miss.

Verification
REQ-030 Cold miss: request 0x1040 after reset -> M_R_ADDR=0x1040 pulse one cycle; beats 0x0..0x7 -> S_R_DATA[63:0]=0x0, [511:448]=0x7, one-cycle S_R_DATA_VALID.
REQ-031 Hit: repeat 0x1047 -> no M_R_ADDR_VALID, S_R_DATA_VALID 2 cycles after accept, same 512-bit data.
REQ-032 Conflict: request 0x1040 + (LINE_COUNT*64) -> miss to that aligned address; then 0x1040 misses again.
REQ-033 Gapped beats: 8 beats with 0-3 idle cycles between -> correct assembly, response exactly one cycle after 8th beat's edge +1.
REQ-034 Reset after beat 4 of a fill -> all outputs 0 immediately; remaining beats ignored; rerequest of same address misses.
REQ-035 Stray M_R_DATA_VALID pulses in IDLE -> no output change, cache contents unchanged.
